// File: rtl/lc2k_instr_encoder_loader_if.sv
// Field-beat stream into the LC2K encoder and the instruction-memory write port it drives.
// The loader takes the slave side; the producer or bench takes the master side.
interface lc2k_instr_encoder_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [2:0]        in_regA;
    logic [2:0]        in_regB;
    logic [2:0]        in_destReg;
    logic [15:0]       in_offset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [24:0]       mem_wdata;

    modport slave (
        input  in_valid, in_opcode, in_regA, in_regB, in_destReg, in_offset,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_opcode, in_regA, in_regB, in_destReg, in_offset,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lc2k_instr_encoder_loader.sv
// Packs LC2K instruction fields into 25-bit words and writes them to consecutive addresses, 1 cycle after acceptance.
// in_ready is high only while RUN; the session ends on HALT or on writing the last address.
module lc2k_instr_encoder_loader #(
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    lc2k_instr_encoder_loader_if.slave bus,
    output logic                      busy,
    output logic                      done,
    output logic                      halt_seen,
    output logic                      full,
    output logic [ADDR_W:0]           word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              halt_seen_q, halt_seen_d;
    logic              full_q, full_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [24:0]       mem_wdata_q, mem_wdata_d;
    logic              accept;

    function automatic logic [24:0] encode(input logic [2:0] op, input logic [2:0] ra,
                                           input logic [2:0] rb, input logic [2:0] rd,
                                           input logic [15:0] off);
        logic [24:0] w;
        w = {op, ra, rb, 16'h0000};
        case (op)
            OP_ADD, OP_NOR:        w[2:0]  = rd;
            OP_LW, OP_SW, OP_BEQ:  w[15:0] = off;
            OP_JALR:               w[15:0] = 16'h0000;
            default:               w[21:0] = 22'd0;
        endcase
        return w;
    endfunction

    assign accept = (state_q == S_RUN) && bus.in_valid;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        halt_seen_d  = halt_seen_q;
        full_d       = full_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    addr_d       = base_addr;
                    word_count_d = '0;
                    halt_seen_d  = 1'b0;
                    full_d       = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wdata_d  = encode(bus.in_opcode, bus.in_regA, bus.in_regB,
                                          bus.in_destReg, bus.in_offset);
                    addr_d       = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    // HALT and last-address are independent; both flags may set on one beat.
                    if (bus.in_opcode == OP_HALT) begin
                        halt_seen_d = 1'b1;
                        state_d     = S_DONE;
                    end
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            word_count_q <= '0;
            halt_seen_q  <= 1'b0;
            full_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            halt_seen_q  <= halt_seen_d;
            full_q       <= full_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign halt_seen     = halt_seen_q;
    assign full          = full_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_lc2k_instr_encoder_loader.sv
// Randomized and directed loads against a session-level reference model; writes checked by a queue-based monitor.
module tb_lc2k_instr_encoder_loader;

    localparam int AW   = 5;
    localparam int LAST = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy, done, halt_seen, full;
    logic [AW:0]   word_count;

    lc2k_instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

    lc2k_instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .halt_seen  (halt_seen),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int addr;
        int word;
    } wr_t;
    wr_t exp_q[$];

    // Reference session: running / finished flags plus counters.
    bit m_run, m_fin, m_halt, m_full;
    int m_addr, m_count;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    function automatic int enc_ref(input int op, input int a, input int b, input int d, input int off);
        int body;
        if (op >= 6) return op << 22;
        if (op <= 1)      body = d;
        else if (op <= 4) body = off;
        else              body = 0;
        return (op << 22) | (a << 19) | (b << 16) | body;
    endfunction

    // One clock of stimulus; entered and left on a negative edge.
    task automatic step(input bit r, input bit s, input int base, input bit v,
                        input int op, input int a, input int b, input int d, input int off);
        check("in_ready",   int'(bus.in_ready), int'(m_run));
        check("busy",       int'(busy),         int'(m_run));
        check("done",       int'(done),         int'(m_fin));
        check("halt_seen",  int'(halt_seen),    int'(m_halt));
        check("full",       int'(full),         int'(m_full));
        check("word_count", int'(word_count),   m_count);

        rst            = r;
        start          = s;
        base_addr      = AW'(base);
        bus.in_valid   = v;
        bus.in_opcode  = 3'(op);
        bus.in_regA    = 3'(a);
        bus.in_regB    = 3'(b);
        bus.in_destReg = 3'(d);
        bus.in_offset  = 16'(off);

        if (r) begin
            m_run = 0; m_fin = 0; m_halt = 0; m_full = 0; m_addr = 0; m_count = 0;
        end else if (!m_run && s) begin
            m_run = 1; m_fin = 0; m_halt = 0; m_full = 0; m_addr = base; m_count = 0;
        end else if (m_run && v) begin
            exp_q.push_back('{due: cyc + 1, addr: m_addr,
                              word: enc_ref(op, a, b, d, off & 16'hFFFF)});
            m_count++;
            if (op == 6)       m_halt = 1;
            if (m_addr == LAST) m_full = 1;
            if (op == 6 || m_addr == LAST) begin
                m_run = 0;
                m_fin = 1;
            end
            m_addr = (m_addr + 1) & LAST;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input int base);
        step(0, 1, base, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input int op, input int a, input int b, input int d, input int off);
        step(0, 0, 0, 1, op, a, b, d, off);
    endtask

    task automatic check_write_port_cleared();
        check("rst_mem_we",    int'(bus.mem_we),    0);
        check("rst_mem_addr",  int'(bus.mem_addr),  0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
    endtask

    // Write monitor: every mem_we must match the oldest expected write, in the exact cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("missing_write", exp_q[0].due, -1);
            void'(exp_q.pop_front());
        end
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(bus.mem_addr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.due);
                check("mem_addr",    int'(bus.mem_addr),  e.addr);
                check("mem_wdata",   int'(bus.mem_wdata), e.word);
            end
        end else if (bus.mem_we !== 1'b0) begin
            check("mem_we_known", 1, 0);
        end
    end

    initial begin
        rst = 1; start = 0; base_addr = '0;
        bus.in_valid = 0; bus.in_opcode = '0; bus.in_regA = '0; bus.in_regB = '0;
        bus.in_destReg = '0; bus.in_offset = '0;
        m_run = 0; m_fin = 0; m_halt = 0; m_full = 0; m_addr = 0; m_count = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_write_port_cleared();

        // Single R-type beat; offset must be ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        go(0);
        beat(0, 1, 2, 3, 16'hFFF8);
        idle();

        // Back-to-back I-type and J-type.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        go(0);
        beat(2, 0, 1, 0, 5);
        beat(2, 0, 1, 0, 16'hFFFF);
        beat(4, 1, 1, 0, 16'hFFFD);
        beat(5, 4, 2, 0, 16'h1234);
        idle();
        idle();

        // HALT terminates; the trailing add stays valid but is never taken.
        go(3);
        beat(7, 5, 6, 7, 16'h7777);
        beat(6, 3, 3, 3, 16'hAAAA);
        beat(0, 1, 1, 1, 0);
        beat(0, 1, 1, 1, 0);
        idle();

        // Last-address boundary.
        go(LAST - 1);
        beat(0, 1, 2, 3, 0);
        beat(0, 2, 3, 4, 0);
        beat(0, 3, 4, 5, 0);
        idle();

        // HALT on the last address sets both flags.
        go(LAST);
        beat(6, 0, 0, 0, 0);
        idle();

        // Mid-RUN start ignored; restart from DONE at 0x10; reset discards a beat.
        go(0);
        beat(1, 1, 2, 3, 0);
        step(0, 1, 7, 1, 1, 2, 3, 4, 0);
        beat(6, 0, 0, 0, 0);
        go(16);
        beat(3, 2, 5, 0, 16'h8001);
        step(1, 0, 0, 1, 0, 7, 7, 7, 0);
        check_write_port_cleared();
        idle();

        // Valid gap in RUN.
        go(8);
        beat(0, 1, 1, 1, 0);
        idle();
        beat(4, 2, 2, 0, 16'h0010);
        idle();
        idle();

        // Randomized sessions, biased towards the top of memory so full is reached often.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, v;
            int base;
            r    = ($urandom_range(99) == 0);
            s    = ($urandom_range(11) == 0);
            base = ($urandom_range(1) == 0) ? LAST - int'($urandom_range(4)) : int'($urandom_range(LAST));
            v    = ($urandom_range(3) != 0);
            step(r, s, base, v, int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(16'hFFFF)));
        end

        idle();
        idle();
        check("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc2k_instr_encoder_loader.md
Name: lc2k_instr_encoder_loader

Overview:
- Inverse of the LC2K instruction decoder: accepts instruction fields over a valid/ready stream and packs them into 25-bit LC2K machine words.
- Writes the words sequentially into instruction memory starting at a programmable base address.
- Used by the bench/boot path to load programs into the processor's instruction memory.
- The load stops on the first HALT or when the memory runs out of addresses.

Parameters:
- ADDR_W, 16, instruction memory address width; the last address is 2^ADDR_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a load session
- base_addr  in  ADDR_W  first write address, sampled on an accepted start
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder can accept a beat
- in_opcode  in  3  000 add, 001 nor, 010 lw, 011 sw, 100 beq, 101 jalr, 110 halt, 111 noop
- in_regA  in  3  regA field
- in_regB  in  3  regB field
- in_destReg  in  3  destReg field (R-type only)
- in_offset  in  16  two's-complement offset (I-type only)
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  25  encoded instruction
- busy  out  1  state is RUN
- done  out  1  state is DONE
- halt_seen  out  1  session ended on a HALT
- full  out  1  session wrote address 2^ADDR_W-1
- word_count  out  ADDR_W+1  words written since the last accepted start

Behaviour:
- Reset (rst=1 at a clk edge, including mid-session):
  - state goes to IDLE.
  - mem_we, mem_addr, mem_wdata, halt_seen, full, done and word_count all go to 0.
  - Any encoded beat not yet written is discarded.
- Encoding. Fields always sit at opcode[24:22], regA[21:19], regB[18:16]. The remaining bits are filled per instruction type:
  - R-type (000, 001): [15:3]=0, [2:0]=destReg; in_offset ignored.
  - I-type (010, 011, 100): [15:0]=in_offset; destReg ignored.
  - J-type (101): [15:0]=0.
  - O-type (110, 111): [21:0]=0; all register and offset inputs ignored.
- State machine with states IDLE, RUN, DONE:
  - IDLE: in_ready=0. A start moves to RUN; addr<=base_addr, word_count<=0, halt_seen<=0, full<=0.
  - RUN: in_ready=1 combinationally. A beat is accepted when in_valid & in_ready. start is ignored in RUN.
  - DONE: in_ready=0; done=1 is held. A start re-enters RUN with the same initialisation as from IDLE.
- Write timing:
  - Latency is exactly 1 cycle from acceptance to write.
  - In the cycle after an accepted beat: mem_we=1, mem_addr=the address at acceptance, mem_wdata=the encoded word.
  - addr and word_count are incremented on the acceptance edge.
  - mem_we is a 1-cycle pulse per beat. Back-to-back beats give back-to-back writes at consecutive addresses.
- Termination:
  - Accepting a beat with opcode 110: halt_seen<=1 and state->DONE on the same edge. The HALT word is still written in the following cycle.
  - Accepting a beat at addr=2^ADDR_W-1: full<=1 and state->DONE. The address counter does not wrap into a further write.
  - If both occur on the same beat, halt_seen and full are both set.
  - Because in_ready drops the cycle after the terminating acceptance, no beat after the terminating one is ever accepted.
- Status persistence: halt_seen, full and word_count hold their values in DONE until the next accepted start or rst.
- done, busy and in_ready are decoded from state only, never from the inputs.
- in_valid while in IDLE or DONE is ignored. No beat is lost because in_ready=0 in those states.

Test Plan:
- Single R-type beat: rst, start with base_addr=0, beat add regA=1 regB=2 destReg=3 in_offset=0xFFF8 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00A0003.
- Back-to-back I-type and J-type writes:
  - Beats: lw 0,1,5; lw 0,1,-1; beq 1,1,-3; jalr 4,2 with in_offset=0x1234.
  - Required writes at addr 0..3: 0x0810005, 0x081FFFF, 0x109FFFD, 0x1620000 on consecutive cycles.
  - word_count=4 at the end.
- HALT termination: beats noop then halt then an extra add held valid -> writes 0x1C00000, 0x1800000; in_ready=0 from the cycle after halt acceptance; done=1, halt_seen=1, word_count=2; add never written.
- Full boundary: ADDR_W=3, base_addr=6, two add beats -> writes at addr 6 and 7; full=1, done=1, halt_seen=0, word_count=2; in_ready=0 afterwards.
- Restart and reset:
  - Mid-RUN start is ignored and addr keeps incrementing.
  - start in DONE with base_addr=0x10 -> next write at 0x10 and word_count restarts at 0.
  - rst asserted with a beat just accepted -> the next cycle has mem_we=0 and all status outputs are 0.
- Backpressure gaps: in_valid toggled 1,0,1 in RUN -> exactly 2 writes, to consecutive addresses; no write in the cycle after the idle cycle.
